uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage, downstream of the UART transmitter: consumes the serial line the transmitter drives and recovers 8-bit bytes. Samples an 8N1 frame (start, 8 data bits LSB first, stop) at bit centres using a clock-cycle bit timer. Delivers each good byte with a one-cycle valid pulse and flags bad stop bits.

---
 rtl/uart_receiver.sv | 179 +++++++++++++++++
 tb/tb_uart_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// ============================================================================
// Module   : uart_receiver
// Purpose  : 8N1 UART receiver. It samples each bit at its centre using a
//            cycle-count bit timer and flags bad stop bits.
//            Defining UART_RX_PARITY_EN adds an even-parity bit and parity_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam logic [15:0] c_half = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] c_full = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_timer;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
`ifdef UART_RX_PARITY_EN
  logic        r_par_bit;
`endif
  logic        w_rx_s;

  assign w_rx_s = r_sync2;

  // The synchronizer resets to the idle level so reset release cannot fake a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_timer <= 16'd0;
          if (!w_rx_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_timer == c_half) begin
            r_timer   <= 16'd0;
            r_bit_idx <= 3'd0;
            if (!w_rx_s) begin
              r_state <= S_DATA;
              rx_busy <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        S_DATA: begin
          if (r_timer == c_full) begin
            r_timer   <= 16'd0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_timer == c_full) begin
            r_timer   <= 16'd0;
            r_par_bit <= w_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
`endif

        S_STOP: begin
          if (r_timer == c_full) begin
            r_timer <= 16'd0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
              rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if ((^r_shift) != r_par_bit) begin
                parity_err <= 1'b1;
              end else begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
              end
`else
              rx_data  <= r_shift;
              rx_valid <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_WAIT_IDLE;
            end
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        // A held-low line (break) must return high before a new start is armed.
        S_WAIT_IDLE: begin
          r_timer <= 16'd0;
          if (w_rx_s) begin
            r_state <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_timer <= 16'd0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Scoreboard bench for uart_receiver: directed and random 8N1 frames
//            against a frame-level expected-event queue (parity when UART_RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_receiver;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
  logic       perr;
`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  uart_receiver #(.CLKS_PER_BIT(BIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(perr),
`endif
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = good byte, 1 = frame error, 2 = parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] last_good = 8'h00;
  bit         glitch_watch = 1'b0;
  bit         busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per reported event.
  initial begin : monitor
    bit prev_pulse;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (glitch_watch && rx_busy) busy_seen = 1'b1;
      if (rx_valid || frame_err || perr) begin
        exp_t e;
        int   kind;
        kind = rx_valid ? 0 : (frame_err ? 1 : 2);
        check("pulse_exclusive", 32'(int'(rx_valid) + int'(frame_err) + int'(perr)), 32'd1);
        check("pulse_not_back_to_back", 32'(prev_pulse), 32'd0);
        if (q.size() == 0) begin
          check("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("event_kind", 32'(kind), 32'(e.kind));
          check("rx_data", 32'(rx_data), 32'(e.data));
        end
        prev_pulse = 1'b1;
      end else begin
        prev_pulse = 1'b0;
      end
    end
  end

  task automatic drive(input logic b, input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = b;
    end
  endtask

  // Reference: a frame yields one event, decided from stop bit and even parity.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    exp_t e;
    if (!stop_ok) begin
      e.kind = 1; e.data = last_good;
    end else if (PAR_EN && !par_ok) begin
      e.kind = 2; e.data = last_good;
    end else begin
      e.kind = 0; e.data = d; last_good = d;
    end
    q.push_back(e);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        drive(d[i], BIT / 2);
        check("busy_mid_frame", 32'(rx_busy), 32'd1);
        drive(d[i], BIT - BIT / 2);
      end else begin
        drive(d[i], BIT);
      end
    end
    if (PAR_EN) drive(par_ok ? ^d : ~^d, BIT);
    drive(stop_ok, BIT);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
    check({tag, "_parity_err"}, 32'(perr), 32'd0);
  endtask

  initial begin : stim
    int timeout;
    rx_in = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    drive(1'b1, 2 * BIT);

    send_frame(8'hA5, 1'b1, 1'b1);
    drive(1'b1, 2 * BIT);
    check("busy_after_frame", 32'(rx_busy), 32'd0);

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    drive(1'b1, 2 * BIT);

    // A short low glitch must be rejected at start validation.
    glitch_watch = 1'b1;
    busy_seen = 1'b0;
    drive(1'b0, 6);
    drive(1'b1, 40);
    glitch_watch = 1'b0;
    check("glitch_busy_seen", 32'(busy_seen), 32'd0);
    check("glitch_no_event", 32'(q.size()), 32'd0);

    send_frame(8'h5A, 1'b0, 1'b1);
    drive(1'b0, 40);
    drive(1'b1, 2 * BIT);
    send_frame(8'h81, 1'b1, 1'b1);
    drive(1'b1, 2 * BIT);

    // Reset after data bit 3 of 0xC3; the partial frame must vanish.
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'(8'hC3 >> i), BIT);
    rst_n = 1'b0;
    last_good = 8'h00;
    @(negedge clk);
    check_reset_outputs("midreset");
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3 * BIT);
    check_reset_outputs("post_reset");
    send_frame(8'h7E, 1'b1, 1'b1);
    drive(1'b1, 2 * BIT);

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b1);
      drive(1'b1, 2 * BIT);
      send_frame(8'h07, 1'b1, 1'b0);
      drive(1'b1, 2 * BIT);
    end

    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit         stop_ok;
      bit         par_ok;
      d       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 5) != 0);
      par_ok  = ($urandom_range(0, 3) != 0);
      send_frame(d, stop_ok, par_ok);
      if (!stop_ok) begin
        drive(1'b0, $urandom_range(0, 30));
        drive(1'b1, BIT);
      end
      drive(1'b1, $urandom_range(0, 2) * BIT);
    end

    timeout = 0;
    while (q.size() != 0 && timeout < 4000) begin
      @(negedge clk);
      timeout++;
    end
    drive(1'b1, 2 * BIT);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
